// File: rtl/tnoc_input_unit.sv
// tnoc_input_unit
//
// Input side of one router port. Incoming flits go into a small FIFO. The
// head flit at the front of the FIFO is XY-routed to one of five outputs.
// The unit requests that output, waits for the switch grant, and then
// streams the packet until its tail flit is transferred.
//
// Optional feature macro: TNOC_INPUT_UNIT_ORPHAN_CHECK_EN
//   defined   : a non-head flit found at the FIFO front while idle is dropped
//               (popped in one cycle) and o_error pulses in that cycle.
//   undefined : no check; such a flit is routed as if it were a head flit,
//               and o_error stays 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_flit_valid      input flit valid
//   o_flit_ready      input ready (FIFO not full), depends on count only
//   i_flit            input flit: bit0 head, bit1 tail, then dest X, dest Y
//   o_output_request  one-hot request [0]X+ [1]X- [2]Y+ [3]Y- [4]local
//   i_output_grant    grant from the switches, one-hot or zero
//   o_valid           per-output flit valid, at most one bit set
//   i_ready           per-output ready
//   o_flit            FIFO front flit, shared by all outputs
//   o_error           orphan-drop pulse (macro builds only)
//   dbg_state         FSM state: 0 IDLE, 1 REQUEST, 2 ACTIVE
//   dbg_count         FIFO occupancy
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on the same lane; valid never waits on ready.

module tnoc_input_unit #(
    parameter int FLIT_WIDTH  = 32,
    parameter int COORD_WIDTH = 3,
    parameter int LOCAL_X     = 0,
    parameter int LOCAL_Y     = 0,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flit_valid,
    output logic                     o_flit_ready,
    input  logic [FLIT_WIDTH-1:0]    i_flit,
    output logic [4:0]               o_output_request,
    input  logic [4:0]               i_output_grant,
    output logic [4:0]               o_valid,
    input  logic [4:0]               i_ready,
    output logic [FLIT_WIDTH-1:0]    o_flit,
    output logic                     o_error,
    output logic [1:0]               dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COORD_WIDTH-1:0] LX = COORD_WIDTH'(LOCAL_X);
    localparam logic [COORD_WIDTH-1:0] LY = COORD_WIDTH'(LOCAL_Y);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t                  state;
    logic [4:0]              route_q;
    logic [4:0]              route_next;
    logic [FLIT_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    xfer_pop;
    logic                    orphan;
    logic [COORD_WIDTH-1:0]  head_x;
    logic [COORD_WIDTH-1:0]  head_y;

    assign empty        = (count == '0);
    assign o_flit_ready = (count != CNT_W'(DEPTH));
    // A full FIFO refuses input even when a pop happens in the same cycle.
    assign push         = i_flit_valid && o_flit_ready;
    assign o_flit       = mem[rd_ptr];

    assign head_x = o_flit[2 +: COORD_WIDTH];
    assign head_y = o_flit[2 + COORD_WIDTH +: COORD_WIDTH];

`ifdef TNOC_INPUT_UNIT_ORPHAN_CHECK_EN
    assign orphan = (state == IDLE) && !empty && !o_flit[0];
`else
    assign orphan = 1'b0;
`endif
    assign o_error = orphan;

    // XY routing: resolve X first, then Y, otherwise deliver locally.
    always_comb begin
        route_next = 5'b10000;
        if (head_x > LX)      route_next = 5'b00001;
        else if (head_x < LX) route_next = 5'b00010;
        else if (head_y > LY) route_next = 5'b00100;
        else if (head_y < LY) route_next = 5'b01000;
    end

    // Request is held from REQUEST through the whole packet.
    assign o_output_request = (state != IDLE) ? route_q : 5'b00000;
    assign o_valid          = (state == ACTIVE && !empty) ? route_q : 5'b00000;
    assign xfer_pop         = |(o_valid & i_ready);
    assign pop              = xfer_pop || orphan;

    assign dbg_state = state;
    assign dbg_count = count;

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_flit;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Packet FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            route_q <= 5'b00000;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && !orphan) begin
                        route_q <= route_next;
                        state   <= REQUEST;
                    end
                end
                REQUEST: begin
                    // Grants on lanes other than our route are ignored.
                    if ((i_output_grant & route_q) != 5'b00000) state <= ACTIVE;
                end
                ACTIVE: begin
                    // Grant loss here is a protocol violation; stay put.
                    if (xfer_pop && o_flit[1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
